// File: rtl/sprite_pkg.sv
// Shared types, colours and the per-axis bounce step for the sprite engine.
// Used by sprite_rom and sprite_engine (optional feature macro: SPRITE_COLLISION_EN).
package sprite_pkg;

    typedef logic signed [10:0] coord_t;
    typedef logic        [11:0] rgb_t;
    typedef logic signed [3:0]  vel_t;

    localparam rgb_t TRANSPARENT = 12'h000;
    localparam rgb_t RED         = 12'hF00;
    localparam rgb_t GREEN       = 12'h0F0;

    typedef struct packed {
        coord_t pos;
        vel_t   vel;
    } axis_t;

    // -8 has no positive counterpart in 4 bits, so it reverses to +7.
    function automatic vel_t neg_sat(input vel_t v);
        return (v == 4'sb1000) ? 4'sd7 : -v;
    endfunction

    function automatic axis_t step_axis(input coord_t pos, input vel_t vel,
                                        input int size, input int dim);
        int    np;
        axis_t res;
        np      = int'(pos) + int'(vel);
        res.pos = coord_t'(np);
        res.vel = vel;
        if (np < 0) begin
            res.pos = '0;
            res.vel = neg_sat(vel);
        end else if (np + size > dim) begin
            res.pos = coord_t'(dim - size);
            res.vel = neg_sat(vel);
        end
        return res;
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite bitmap ROM: one registered read port per sprite, addressed by
// {sprite_id, rel_r, rel_c}; default content is a red/green checkerboard.
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16,
    parameter int AW          = $clog2(NUM_SPRITES) + $clog2(SPRITE_H) + $clog2(SPRITE_W)
) (
    input  logic                      clk,
    input  logic [NUM_SPRITES*AW-1:0] addr,
    output logic [NUM_SPRITES*12-1:0] data
);

    localparam int CW    = $clog2(SPRITE_W);
    localparam int DEPTH = 1 << AW;

    rgb_t rom_table [DEPTH];

    // Bit CW of the address is rel_r[0], bit 0 is rel_c[0].
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_table
        localparam logic [AW-1:0] A = AW'(gi);
        assign rom_table[gi] = (A[CW] ^ A[0]) ? GREEN : RED;
    end

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : gen_port
        rgb_t rd_reg;
        always_ff @(posedge clk) begin
            rd_reg <= rom_table[addr[gi*AW +: AW]];
        end
        assign data[gi*12 +: 12] = rd_reg;
    end

endmodule

// File: rtl/sprite_engine.sv
// Two-stage pipelined multi-sprite renderer with per-frame bouncing motion.
// Optional sticky sprite-overlap flag when built with SPRITE_COLLISION_EN.
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int         NUM_SPRITES = 4,
    parameter int         SPRITE_W    = 16,
    parameter int         SPRITE_H    = 16,
    parameter int         SCREEN_COLS = 640,
    parameter int         SCREEN_ROWS = 480,
    parameter logic [11:0] BG_COLOUR  = 12'h000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_start,
    input  logic                           pix_valid,
    input  logic [10:0]                    row,
    input  logic [10:0]                    column,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_SPRITES)-1:0] wr_sel,
    input  logic [10:0]                    wr_row,
    input  logic [10:0]                    wr_col,
    input  logic [3:0]                     wr_vrow,
    input  logic [3:0]                     wr_vcol,
    output logic [11:0]                    q,
    output logic                           q_valid,
    output logic [NUM_SPRITES-1:0]         hit
`ifdef SPRITE_COLLISION_EN
    ,
    output logic                           collision
`endif
);

    localparam int SEL_W = $clog2(NUM_SPRITES);
    localparam int RW    = $clog2(SPRITE_H);
    localparam int CW    = $clog2(SPRITE_W);
    localparam int AW    = SEL_W + RW + CW;

    logic [NUM_SPRITES*AW-1:0] rom_addr;
    logic [NUM_SPRITES*12-1:0] rom_data;
    logic [NUM_SPRITES-1:0]    in_range;
    logic [NUM_SPRITES-1:0]    inr2_reg;
    logic                      valid1_reg;
    logic                      valid2_reg;

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : gen_sprite
        coord_t pos_row_reg, pos_col_reg;
        vel_t   vel_row_reg, vel_col_reg;
        coord_t rel_r_reg, rel_c_reg;
        axis_t  row_next, col_next;
        logic   sel_this;

        assign sel_this = wr_en && (wr_sel == SEL_W'(gi));
        assign row_next = step_axis(pos_row_reg, vel_row_reg, SPRITE_H, SCREEN_ROWS);
        assign col_next = step_axis(pos_col_reg, vel_col_reg, SPRITE_W, SCREEN_COLS);

        // A host write in the frame_start cycle overrides that sprite's motion.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pos_row_reg <= '0;
                pos_col_reg <= '0;
                vel_row_reg <= '0;
                vel_col_reg <= '0;
            end else if (sel_this) begin
                pos_row_reg <= wr_row;
                pos_col_reg <= wr_col;
                vel_row_reg <= wr_vrow;
                vel_col_reg <= wr_vcol;
            end else if (frame_start) begin
                pos_row_reg <= row_next.pos;
                pos_col_reg <= col_next.pos;
                vel_row_reg <= row_next.vel;
                vel_col_reg <= col_next.vel;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rel_r_reg <= '0;
                rel_c_reg <= '0;
            end else begin
                rel_r_reg <= row - pos_row_reg;
                rel_c_reg <= column - pos_col_reg;
            end
        end

        // Sizes are powers of two: in range iff every bit above the offset is zero.
        assign in_range[gi] = (rel_r_reg[10:RW] == '0) && (rel_c_reg[10:CW] == '0);
        assign rom_addr[gi*AW +: AW] = {SEL_W'(gi), rel_r_reg[RW-1:0], rel_c_reg[CW-1:0]};
    end

    sprite_rom #(
        .NUM_SPRITES (NUM_SPRITES),
        .SPRITE_W    (SPRITE_W),
        .SPRITE_H    (SPRITE_H),
        .AW          (AW)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_reg <= 1'b0;
            valid2_reg <= 1'b0;
            inr2_reg   <= '0;
        end else begin
            valid1_reg <= pix_valid;
            valid2_reg <= valid1_reg;
            inr2_reg   <= in_range;
        end
    end

    // Walk from the highest index down so the lowest-index opaque sprite wins.
    always_comb begin
        hit = '0;
        q   = BG_COLOUR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (valid2_reg && inr2_reg[i] && (rom_data[i*12 +: 12] != TRANSPARENT)) begin
                hit[i] = 1'b1;
                q      = rom_data[i*12 +: 12];
            end
        end
    end

    assign q_valid = valid2_reg;

`ifdef SPRITE_COLLISION_EN
    logic multi_hit;
    logic collision_reg;

    assign multi_hit = (hit & (hit - NUM_SPRITES'(1))) != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_reg <= 1'b0;
        end else if (multi_hit) begin
            collision_reg <= 1'b1;
        end else if (frame_start) begin
            collision_reg <= 1'b0;
        end
    end

    assign collision = collision_reg;
`endif

endmodule

// File: tb/tb_sprite_engine.sv
// Scoreboard bench for sprite_engine: directed pixel queries queue their
// expected output; a forked monitor pops and compares on each q_valid.
module tb_sprite_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [10:0] row = '0;
    logic [10:0] column = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_sel = '0;
    logic [10:0] wr_row = '0;
    logic [10:0] wr_col = '0;
    logic [3:0]  wr_vrow = '0;
    logic [3:0]  wr_vcol = '0;
    logic [11:0] q;
    logic        q_valid;
    logic [3:0]  hit;
`ifdef SPRITE_COLLISION_EN
    logic        collision;
`endif

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic [11:0] q;
        logic [3:0]  hit;
        int          r;
        int          c;
    } exp_t;

    exp_t sb[$];

    sprite_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .row         (row),
        .column      (column),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_vrow     (wr_vrow),
        .wr_vcol     (wr_vcol),
        .q           (q),
        .q_valid     (q_valid),
        .hit         (hit)
`ifdef SPRITE_COLLISION_EN
        ,
        .collision   (collision)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        wr_en       = 1'b0;
        pix_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pixel_fs(input int r, input int c, input logic [11:0] eq,
                            input logic [3:0] eh, input logic fs);
        exp_t e;
        tick();
        pix_valid   = 1'b1;
        frame_start = fs;
        row         = 11'(r);
        column      = 11'(c);
        e.cyc = cyc + 2;
        e.q   = eq;
        e.hit = eh;
        e.r   = r;
        e.c   = c;
        sb.push_back(e);
    endtask

    task automatic pixel(input int r, input int c, input logic [11:0] eq, input logic [3:0] eh);
        pixel_fs(r, c, eq, eh, 1'b0);
    endtask

    task automatic write_sprite(input int sel, input int r, input int c,
                                input int vr, input int vc, input logic fs);
        tick();
        wr_en       = 1'b1;
        frame_start = fs;
        wr_sel      = 2'(sel);
        wr_row      = 11'(r);
        wr_col      = 11'(c);
        wr_vrow     = 4'(vr);
        wr_vcol     = 4'(vc);
    endtask

    task automatic frame();
        tick();
        frame_start = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL latency_timeout: no q_valid for (%0d,%0d), required at cycle %0d", e.r, e.c, e.cyc);
            end
            if (q_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_q_valid: q_valid=1 with nothing expected, required 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    $display("txn (%0d,%0d): q=%h hit=%b cycle=%0d", e.r, e.c, q, hit, cyc);
                    check("latency", cyc, e.cyc);
                    check("q", 32'(q), 32'(e.q));
                    check("hit", 32'(hit), 32'(e.hit));
                end
            end else if (rst_n && hit != 4'b0000) begin
                check("idle_hit", 32'(hit), 32'd0);
            end
        end
    endtask

    initial begin
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1);
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_q", 32'(q), 32'h000);
        check("reset_q_valid", 32'(q_valid), 32'd0);
        check("reset_hit", 32'(hit), 32'd0);
`ifdef SPRITE_COLLISION_EN
        check("reset_collision", 32'(collision), 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        pixel(300, 300, 12'h000, 4'b0000);
        idle(3);

        // In-flight lookup is discarded by a mid-stream reset
        tick();
        pix_valid = 1'b1;
        row       = 11'd300;
        column    = 11'd300;
        tick();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        pixel(300, 300, 12'h000, 4'b0000);
        idle(3);

        // Single static sprite: checkerboard and edges
        write_sprite(0, 100, 100, 0, 0, 1'b0);
        pixel(100, 100, 12'hF00, 4'b0001);
        pixel(100, 101, 12'h0F0, 4'b0001);
        pixel(115, 115, 12'hF00, 4'b0001);
        pixel(99, 100, 12'h000, 4'b0000);
        pixel(116, 100, 12'h000, 4'b0000);
        pixel(100, 116, 12'h000, 4'b0000);

        // Overlap: sprite 0 has priority
        write_sprite(1, 100, 100, 0, 0, 1'b0);
        pixel(100, 101, 12'h0F0, 4'b0011);
        idle(3);
`ifdef SPRITE_COLLISION_EN
        check("collision_set", 32'(collision), 32'd1);
        frame();
        idle(1);
        check("collision_clear", 32'(collision), 32'd0);
`endif
        write_sprite(1, 100, 110, 0, 0, 1'b0);
        pixel(100, 112, 12'hF00, 4'b0011);
        pixel(101, 120, 12'h0F0, 4'b0010);

        // Linear motion of sprite 2
        write_sprite(2, 200, 300, 3, -2, 1'b0);
        frame();
        pixel(203, 298, 12'hF00, 4'b0100);
        pixel(202, 298, 12'h000, 4'b0000);
        pixel(203, 297, 12'h000, 4'b0000);
        frame();
        frame();
        frame();
        pixel(212, 292, 12'hF00, 4'b0100);
        pixel(211, 292, 12'h000, 4'b0000);
        pixel(212, 291, 12'h000, 4'b0000);
        pixel(227, 307, 12'hF00, 4'b0100);
        pixel(228, 307, 12'h000, 4'b0000);

        // Bottom-edge bounce
        write_sprite(3, 462, 200, 4, 0, 1'b0);
        frame();
        pixel(464, 200, 12'hF00, 4'b1000);
        pixel(463, 200, 12'h000, 4'b0000);
        frame();
        pixel(460, 200, 12'hF00, 4'b1000);
        pixel(459, 200, 12'h000, 4'b0000);

        // Left-edge bounce
        write_sprite(3, 300, 1, 0, -3, 1'b0);
        frame();
        pixel(300, 0, 12'hF00, 4'b1000);
        pixel(300, -1, 12'h000, 4'b0000);
        frame();
        pixel(300, 3, 12'hF00, 4'b1000);
        pixel(300, 2, 12'h000, 4'b0000);

        // -8 reverses to +7
        write_sprite(3, 300, 4, 0, -8, 1'b0);
        frame();
        pixel(300, 0, 12'hF00, 4'b1000);
        frame();
        pixel(300, 7, 12'hF00, 4'b1000);
        pixel(300, 6, 12'h000, 4'b0000);

        // Write beats motion in the same cycle
        write_sprite(0, 50, 50, 5, 5, 1'b1);
        pixel(50, 50, 12'hF00, 4'b0001);
        pixel(49, 50, 12'h000, 4'b0000);
        pixel(50, 49, 12'h000, 4'b0000);

        // Lookup in the frame_start cycle sees the old position
        pixel_fs(50, 50, 12'hF00, 4'b0001, 1'b1);
        pixel(55, 55, 12'hF00, 4'b0001);
        pixel(50, 50, 12'h000, 4'b0000);
        pixel(54, 55, 12'h000, 4'b0000);

        idle(5);
        check("queue_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
